// File: rtl/truth_table_tester.sv
// Stimulus-and-capture engine: walks every input vector of a small combinational
// block, samples its outputs into a packed truth table and grades it against a latched golden table.
module truth_table_tester #(
    parameter int N_IN   = 2,
    parameter int N_OUT  = 2,
    parameter int SETTLE = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [N_OUT*(2**N_IN)-1:0]  expected,
    input  logic [N_OUT-1:0]            dut_out,
    output logic [N_IN-1:0]             dut_in,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [N_IN:0]               err_count,
    output logic [N_IN-1:0]             first_err_idx,
    output logic [N_OUT*(2**N_IN)-1:0]  captured
);

    localparam int N_VEC = 2 ** N_IN;
    localparam int TW    = N_OUT * N_VEC;
    localparam int SW    = $clog2(SETTLE + 2);

    localparam logic [SW-1:0]   SETTLE_INIT = SW'(SETTLE);
    localparam logic [N_IN-1:0] LAST_IDX    = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t             state_r,    state_s;
    logic [N_IN-1:0]    index_r,    index_s;
    logic [SW-1:0]      settle_r,   settle_s;
    logic [TW-1:0]      exp_r,      exp_s;
    logic [TW-1:0]      cap_r,      cap_s;
    logic [N_IN:0]      err_r,      err_s;
    logic [N_IN-1:0]    first_r,    first_s;
    logic               pass_r,     pass_s;
    logic               busy_r,     busy_s;
    logic               done_r,     done_s;
    logic [N_IN-1:0]    dut_in_r,   dut_in_s;
    logic               mismatch_s;
    int unsigned        base_s;

    // Four-state compare so an X or Z on the sampled outputs is graded as a failure.
    function automatic logic slice_mismatch(input logic [N_OUT-1:0] got,
                                            input logic [N_OUT-1:0] want);
        return (got !== want);
    endfunction

    // Next-state and next-output logic for the walk FSM.
    always_comb begin
        state_s    = state_r;
        index_s    = index_r;
        settle_s   = settle_r;
        exp_s      = exp_r;
        cap_s      = cap_r;
        err_s      = err_r;
        first_s    = first_r;
        pass_s     = pass_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        dut_in_s   = dut_in_r;
        base_s     = int'(index_r) * N_OUT;
        mismatch_s = slice_mismatch(dut_out, exp_r[base_s +: N_OUT]);

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    exp_s    = expected;
                    cap_s    = {TW{1'b0}};
                    err_s    = {(N_IN+1){1'b0}};
                    first_s  = {N_IN{1'b0}};
                    pass_s   = 1'b0;
                    index_s  = {N_IN{1'b0}};
                    dut_in_s = {N_IN{1'b0}};
                    settle_s = SETTLE_INIT;
                    busy_s   = 1'b1;
                    state_s  = ST_WAIT;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (settle_r != {SW{1'b0}}) begin
                    settle_s = settle_r - {{(SW-1){1'b0}}, 1'b1};
                end else begin
                    cap_s[base_s +: N_OUT] = dut_out;
                    if (mismatch_s) begin
                        err_s = err_r + {{N_IN{1'b0}}, 1'b1};
                        // Only the lowest failing index is kept; vectors are walked in ascending order.
                        if (err_r == {(N_IN+1){1'b0}}) begin
                            first_s = index_r;
                        end else begin
                            first_s = first_r;
                        end
                    end else begin
                        err_s = err_r;
                    end
                    if (index_r == LAST_IDX) begin
                        state_s = ST_DONE;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        pass_s  = (err_s == {(N_IN+1){1'b0}});
                    end else begin
                        index_s  = index_r + {{(N_IN-1){1'b0}}, 1'b1};
                        dut_in_s = index_r + {{(N_IN-1){1'b0}}, 1'b1};
                        settle_s = SETTLE_INIT;
                    end
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; synchronous active-low reset wins over everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            index_r  <= {N_IN{1'b0}};
            settle_r <= {SW{1'b0}};
            exp_r    <= {TW{1'b0}};
            cap_r    <= {TW{1'b0}};
            err_r    <= {(N_IN+1){1'b0}};
            first_r  <= {N_IN{1'b0}};
            pass_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dut_in_r <= {N_IN{1'b0}};
        end else begin
            state_r  <= state_s;
            index_r  <= index_s;
            settle_r <= settle_s;
            exp_r    <= exp_s;
            cap_r    <= cap_s;
            err_r    <= err_s;
            first_r  <= first_s;
            pass_r   <= pass_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            dut_in_r <= dut_in_s;
        end
    end

    assign dut_in        = dut_in_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign err_count     = err_r;
    assign first_err_idx = first_r;
    assign captured      = cap_r;

endmodule

// File: tb/tb_truth_table_tester.sv
// Directed bench: two testers (SETTLE=1 and SETTLE=0) driving a small gate model
// with dut_out[0]=~x&y and dut_out[1]=x|y (or x&y when the faulty gate is selected).
module tb_truth_table_tester;

    logic       clk;
    logic       rst_n;
    logic       bad_dut;

    logic       start_a,   start_b;
    logic [7:0] expected_a, expected_b;
    logic [1:0] dut_out_a, dut_out_b;
    logic [1:0] dut_in_a,  dut_in_b;
    logic       busy_a,    busy_b;
    logic       done_a,    done_b;
    logic       pass_a,    pass_b;
    logic [2:0] err_a,     err_b;
    logic [1:0] first_a,   first_b;
    logic [7:0] cap_a,     cap_b;

    int checks;
    int failures;
    int done_cnt_a;
    int done_cnt_b;

    truth_table_tester #(.N_IN(2), .N_OUT(2), .SETTLE(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .expected(expected_a),
        .dut_out(dut_out_a), .dut_in(dut_in_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_count(err_a), .first_err_idx(first_a), .captured(cap_a)
    );

    truth_table_tester #(.N_IN(2), .N_OUT(2), .SETTLE(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .expected(expected_b),
        .dut_out(dut_out_b), .dut_in(dut_in_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_count(err_b), .first_err_idx(first_b), .captured(cap_b)
    );

    assign dut_out_a = {bad_dut ? (dut_in_a[1] & dut_in_a[0]) : (dut_in_a[1] | dut_in_a[0]),
                        ~dut_in_a[1] & dut_in_a[0]};
    assign dut_out_b = {dut_in_b[1] | dut_in_b[0], ~dut_in_b[1] & dut_in_b[0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (done_a === 1'b1) done_cnt_a++;
        if (done_b === 1'b1) done_cnt_b++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_dut_in_a"}, 64'(dut_in_a), 64'd0);
        check_eq({tag, "_busy_a"},   64'(busy_a),   64'd0);
        check_eq({tag, "_done_a"},   64'(done_a),   64'd0);
        check_eq({tag, "_pass_a"},   64'(pass_a),   64'd0);
        check_eq({tag, "_err_a"},    64'(err_a),    64'd0);
        check_eq({tag, "_first_a"},  64'(first_a),  64'd0);
        check_eq({tag, "_cap_a"},    64'(cap_a),    64'd0);
        check_eq({tag, "_busy_b"},   64'(busy_b),   64'd0);
        check_eq({tag, "_cap_b"},    64'(cap_b),    64'd0);
    endtask

    // One full SETTLE=1 run; inject 1 = restart at E3 plus expected change, 2 = start in DONE cycle.
    task automatic run_a(input logic [7:0] tab, input logic [7:0] cap_want, input int errs,
                         input int first, input logic pass_want, input int inject);
        int dc0;
        dc0 = done_cnt_a;
        expected_a = tab;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        check_eq("a_e0_busy",   64'(busy_a),   64'd1);
        check_eq("a_e0_dut_in", 64'(dut_in_a), 64'd0);
        check_eq("a_e0_pass",   64'(pass_a),   64'd0);
        check_eq("a_e0_err",    64'(err_a),    64'd0);
        for (int c = 1; c <= 8; c++) begin
            if (inject == 1 && c == 3) begin
                start_a    = 1'b1;
                expected_a = 8'h00;
            end
            step();
            start_a = 1'b0;
            if (c < 8) begin
                check_eq("a_walk_busy",   64'(busy_a),   64'd1);
                check_eq("a_walk_dut_in", 64'(dut_in_a), 64'(c / 2));
                check_eq("a_walk_done",   64'(done_a),   64'd0);
            end
        end
        check_eq("a_e8_done",   64'(done_a),   64'd1);
        check_eq("a_e8_busy",   64'(busy_a),   64'd0);
        check_eq("a_e8_dut_in", 64'(dut_in_a), 64'd3);
        check_eq("a_e8_cap",    64'(cap_a),    64'(cap_want));
        check_eq("a_e8_err",    64'(err_a),    64'(errs));
        check_eq("a_e8_first",  64'(first_a),  64'(first));
        check_eq("a_e8_pass",   64'(pass_a),   64'(pass_want));
        if (inject == 2) start_a = 1'b1;
        step();
        start_a = 1'b0;
        check_eq("a_e9_done", 64'(done_a), 64'd0);
        check_eq("a_e9_cap",  64'(cap_a),  64'(cap_want));
        check_eq("a_e9_pass", 64'(pass_a), 64'(pass_want));
        step();
        check_eq("a_e10_busy",  64'(busy_a),   64'd0);
        check_eq("a_e10_err",   64'(err_a),    64'(errs));
        check_eq("a_done_cnt",  64'(done_cnt_a - dc0), 64'd1);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        done_cnt_a = 0;
        done_cnt_b = 0;
        rst_n      = 1'b0;
        bad_dut    = 1'b0;
        start_a    = 1'b0;
        start_b    = 1'b0;
        expected_a = 8'h00;
        expected_b = 8'h00;

        // Reset and idle behaviour.
        step();
        step();
        check_idle_zero("rst");
        check_eq("rst_no_done", 64'(done_cnt_a + done_cnt_b), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check_idle_zero("idle");
        check_eq("idle_no_done", 64'(done_cnt_a + done_cnt_b), 64'd0);

        // Good gate, then faulty gate.
        run_a(8'hAC, 8'hAC, 0, 0, 1'b1, 0);
        bad_dut = 1'b1;
        run_a(8'hAC, 8'h84, 2, 1, 1'b0, 0);
        bad_dut = 1'b0;

        // Starts during WAIT and DONE are ignored.
        run_a(8'hAC, 8'hAC, 0, 0, 1'b1, 1);
        run_a(8'hAC, 8'hAC, 0, 0, 1'b1, 2);

        // Reset mid-run, then a clean run.
        begin
            int dc0;
            dc0 = done_cnt_a;
            expected_a = 8'hAC;
            start_a = 1'b1;
            step();
            start_a = 1'b0;
            for (int i = 0; i < 4; i++) step();
            check_eq("mid_busy_before_rst", 64'(busy_a), 64'd1);
            rst_n = 1'b0;
            step();
            check_idle_zero("midrst");
            rst_n = 1'b1;
            step();
            step();
            check_eq("midrst_stay_idle", 64'(busy_a), 64'd0);
            check_eq("midrst_no_done",   64'(done_cnt_a - dc0), 64'd0);
        end
        run_a(8'hAC, 8'hAC, 0, 0, 1'b1, 0);

        // SETTLE=0: one cycle per vector, done after E4.
        expected_b = 8'hAC;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        check_eq("b_e0_busy",   64'(busy_b),   64'd1);
        check_eq("b_e0_dut_in", 64'(dut_in_b), 64'd0);
        for (int c = 1; c <= 3; c++) begin
            step();
            check_eq("b_walk_dut_in", 64'(dut_in_b), 64'(c));
            check_eq("b_walk_done",   64'(done_b),   64'd0);
        end
        step();
        check_eq("b_e4_done",  64'(done_b),  64'd1);
        check_eq("b_e4_busy",  64'(busy_b),  64'd0);
        check_eq("b_e4_cap",   64'(cap_b),   64'hAC);
        check_eq("b_e4_err",   64'(err_b),   64'd0);
        check_eq("b_e4_first", 64'(first_b), 64'd0);
        check_eq("b_e4_pass",  64'(pass_b),  64'd1);
        step();
        check_eq("b_e5_done",  64'(done_b),  64'd0);
        step();
        check_eq("b_done_cnt", 64'(done_cnt_b), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/truth_table_tester.md
Name: truth_table_tester

Overview:
Sequential stimulus-and-capture engine that sits on the input side of a small combinational gate block, which is the device under test. On start it walks every input combination of the DUT in binary order and holds each vector for a programmable settle time. It samples the DUT outputs into a packed truth table, compares each sample against an expected table latched at start, and reports pass/fail with a one-cycle done pulse. This replaces hand-written stimulus and $monitor checks in gate-level exercises.

Parameters:
N_IN, 2, number of DUT inputs; the block walks 2^N_IN vectors.
N_OUT, 2, number of DUT outputs captured per vector.
SETTLE, 1, extra cycles each vector is held before sampling. 0 is legal.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  synchronous, active-low reset.
start  input  1  run request; sampled only in IDLE.
expected  input  N_OUT*2^N_IN  golden table; slice [k*N_OUT +: N_OUT] is the expected output for vector k; latched when start is accepted.
dut_out  input  N_OUT  DUT outputs.
dut_in  output  N_IN  vector driven to the DUT; bit N_IN-1 is the first DUT operand.
busy  output  1  high while vectors are being walked.
done  output  1  one-cycle pulse when the run completes.
pass  output  1  1 when err_count==0; valid from done until the next accepted start.
err_count  output  N_IN+1  number of mismatching vectors (0..2^N_IN).
first_err_idx  output  N_IN  lowest mismatching vector index; 0 if there are none.
captured  output  N_OUT*2^N_IN  sampled truth table, same packing as expected.

Behaviour:
- Reset (rst_n==0 at a rising edge) has priority over everything, mid-run included. State goes to IDLE.
- Reset values: dut_in=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0, captured=0, index=0, settle counter=0.
- FSM states: IDLE, WAIT, DONE.
- IDLE, with start==1 at edge E0:
  - latch expected; clear captured, err_count, first_err_idx and pass.
  - set index=0, dut_in=0, settle_cnt=SETTLE, busy=1.
  - go to WAIT.
- WAIT, settle_cnt!=0: decrement settle_cnt.
- WAIT, settle_cnt==0 (sample edge):
  - write captured slice[index] <= dut_out.
  - if dut_out differs from the latched expected slice: err_count++. If this is the first mismatch, first_err_idx <= index.
  - in simulation, any X or Z bit on dut_out counts as a mismatch.
  - if index == 2^N_IN-1: go to DONE and set busy=0, done=1, pass=(final err_count==0), counting this vector's result.
  - otherwise: index++, dut_in <= index+1, settle_cnt <= SETTLE.
- Timing: each vector is held SETTLE+1 cycles. The last sample and the done assertion happen at edge E0 + 2^N_IN*(SETTLE+1).
- DONE: done is high for exactly one cycle, then the FSM returns to IDLE.
  - dut_in holds the last vector.
  - captured, err_count, first_err_idx and pass hold their values until the next accepted start.
- start is ignored in WAIT and DONE. A start pulse during a run does not queue.
- expected may change freely after the accepting edge; only the latched copy is used.
- The index wraps only at the end of a run. There is no free-running counting outside WAIT.
- No combinational path exists from dut_out to any output. All outputs are registered.

Test Plan:
Setup for all scenarios unless noted: N_IN=2, N_OUT=2, SETTLE=1. dut_in={x,y}. DUT computes dut_out[0]=~x&y and dut_out[1]=x|y.
1. Hold rst_n=0 for 2 cycles -> all outputs 0 and no done pulse. Release, keep start=0 for 10 cycles -> outputs stay 0.
2. expected=8'hAC, one start pulse accepted at E0 ->
   - dut_in=0,1,2,3, each held 2 cycles; busy high E0..E8.
   - done high only after E8; captured=8'hAC, err_count=0, first_err_idx=0, pass=1.
3. DUT OR gate replaced by AND, expected=8'hAC -> captured=8'h84, err_count=2, first_err_idx=1, pass=0, done after E8.
4. Good DUT, expected=8'hAC:
   - second start at E3 and expected changed to 8'h00 at E2 -> run unaffected, one done pulse, pass=1.
   - a start in the DONE cycle is also ignored.
5. Reset at E5 mid-run -> next edge has all outputs 0 and state IDLE, with no done. A new start then completes a full run with pass=1.
6. SETTLE=0, good DUT, expected=8'hAC -> one cycle per vector, done after E4, pass=1, captured=8'hAC.
